// File: rtl/ysyx_22040632_div_pkg.sv
// Shared definitions for the iterative radix-2 restoring divider.
// Contents:
//   div_state_t - controller states (IDLE, CALC, FIX, DONE)
//   XLEN        - operand/result width
//   W_ITER      - iterations for word (32-bit) operations
//   D_ITER      - iterations for doubleword (64-bit) operations
//   DIV_ZERO_Q  - quotient returned for division by zero (all ones)
//   sext_word() - sign-extends a 32-bit word result to XLEN
package ysyx_22040632_div_pkg;

   localparam int XLEN   = 64;
   localparam int W_ITER = 32;
   localparam int D_ITER = 64;

   localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   // RV64 word results are always sign-extended from bit 31, signed or not.
   function automatic logic [XLEN-1:0] sext_word(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

endpackage

// File: rtl/ysyx_22040632_div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   rem_in  [XLEN:0]   shifted partial remainder (previous remainder << 1 | next dividend bit)
//   divisor [XLEN-1:0] divisor magnitude
//   rem_out [XLEN-1:0] next partial remainder (difference if it fits, else restored input)
//   q_bit              quotient bit produced by this iteration
// rem_out needs only XLEN bits: in both outcomes the value is below the divisor.
module ysyx_22040632_div_step
   import ysyx_22040632_div_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN:0]   rem_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic            q_bit
);

   logic [XLEN:0] diff;

   always_comb begin
      diff    = rem_in - {1'b0, divisor};
      // A clear sign bit means the trial subtraction did not go negative.
      q_bit   = ~diff[XLEN];
      rem_out = q_bit ? diff[XLEN-1:0] : rem_in[XLEN-1:0];
   end

endmodule

// File: rtl/ysyx_22040632_divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the
// W variants. One quotient bit per cycle; returns quotient and remainder.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   div_valid/div_ready request handshake (accept = valid && ready && !flush)
//   divw                32-bit word operation
//   div_signed          signed operation
//   dividend, divisor   operands (rs1, rs2), sampled only at accept
//   flush               abort; returns to IDLE next cycle
//   out_valid/out_ready result handshake
//   quotient, remainder results, held stable while out_valid is high
module ysyx_22040632_divider #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            div_valid,
   output logic            div_ready,
   input  logic            divw,
   input  logic            div_signed,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   import ysyx_22040632_div_pkg::*;

   div_state_t state_reg, state_next;

   logic [XLEN-1:0] a_adj, b_adj, a_mag, b_mag, min_neg;
   logic            a_neg, b_neg, div_zero, overflow, accept;

   logic [XLEN-1:0] partial_rem_reg, dividend_shift_reg, divisor_reg;
   logic [6:0]      cnt_reg, last_iter;
   logic            word_reg, q_neg_reg, r_neg_reg;

   logic [XLEN-1:0] rem_next, q_fix, r_fix;
   logic            q_bit;

   // Width-adjusted operands, signs, magnitudes and special-case detection.
   always_comb begin
      a_adj = dividend;
      b_adj = divisor;
      if (divw) begin
         a_adj = {{(XLEN-32){div_signed & dividend[31]}}, dividend[31:0]};
         b_adj = {{(XLEN-32){div_signed & divisor[31]}},  divisor[31:0]};
      end
      a_neg    = div_signed & a_adj[XLEN-1];
      b_neg    = div_signed & b_adj[XLEN-1];
      a_mag    = a_neg ? -a_adj : a_adj;
      b_mag    = b_neg ? -b_adj : b_adj;
      // Most-negative value after width adjustment (word form is sign-extended).
      min_neg  = divw ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = (b_adj == '0);
      overflow = div_signed && (a_adj == min_neg) && (b_adj == '1);
      accept   = div_valid && (state_reg == IDLE) && !flush;
   end

   ysyx_22040632_div_step #(.XLEN(XLEN)) u_step (
      .rem_in  ({partial_rem_reg, dividend_shift_reg[XLEN-1]}),
      .divisor (divisor_reg),
      .rem_out (rem_next),
      .q_bit   (q_bit)
   );

   always_comb begin
      last_iter = word_reg ? 7'(W_ITER - 1) : 7'(D_ITER - 1);
      q_fix     = q_neg_reg ? -dividend_shift_reg : dividend_shift_reg;
      r_fix     = r_neg_reg ? -partial_rem_reg : partial_rem_reg;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_next = state_reg;
      div_ready  = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            div_ready = 1'b1;
            if (accept) state_next = (div_zero || overflow) ? DONE : CALC;
         end
         CALC: if (cnt_reg == last_iter) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   // Datapath. Everything is re-initialised on accept, so an aborted
   // operation leaves nothing that can leak into the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         partial_rem_reg    <= '0;
         dividend_shift_reg <= '0;
         divisor_reg        <= '0;
         cnt_reg            <= '0;
         word_reg           <= 1'b0;
         q_neg_reg          <= 1'b0;
         r_neg_reg          <= 1'b0;
         quotient           <= '0;
         remainder          <= '0;
      end else if (accept) begin
         partial_rem_reg    <= '0;
         // Word magnitudes are left-aligned so the same MSB-first shift
         // path serves both widths; the quotient collects in the low bits.
         dividend_shift_reg <= divw ? (a_mag << (XLEN - 32)) : a_mag;
         divisor_reg        <= b_mag;
         cnt_reg            <= '0;
         word_reg           <= divw;
         q_neg_reg          <= a_neg ^ b_neg;
         r_neg_reg          <= a_neg;
         if (div_zero) begin
            quotient  <= DIV_ZERO_Q;
            remainder <= divw ? sext_word(a_adj[31:0]) : a_adj;
         end else if (overflow) begin
            quotient  <= a_adj;
            remainder <= '0;
         end
      end else if (state_reg == CALC) begin
         partial_rem_reg    <= rem_next;
         dividend_shift_reg <= {dividend_shift_reg[XLEN-2:0], q_bit};
         cnt_reg            <= cnt_reg + 7'd1;
      end else if (state_reg == FIX) begin
         quotient  <= word_reg ? sext_word(q_fix[31:0]) : q_fix;
         remainder <= word_reg ? sext_word(r_fix[31:0]) : r_fix;
      end
   end

endmodule

// File: tb/tb_ysyx_22040632_divider.sv
module tb_ysyx_22040632_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        div_valid = 1'b0;
   logic        div_ready;
   logic        divw = 1'b0;
   logic        div_signed = 1'b0;
   logic [63:0] dividend = '0;
   logic [63:0] divisor = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] quotient;
   logic [63:0] remainder;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [63:0] q;
      logic [63:0] r;
   } exp_t;

   typedef struct {
      string       name;
      logic        w;
      logic        s;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] q;
      logic [63:0] r;
      int          lat;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[15];

   always #5 clk = ~clk;

   ysyx_22040632_divider #(.XLEN(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .div_valid  (div_valid),
      .div_ready  (div_ready),
      .divw       (divw),
      .div_signed (div_signed),
      .dividend   (dividend),
      .divisor    (divisor),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%016h required=0x%016h", name, act, exp);
      end
   endtask

   // Issue one request, check latency, optionally stall the result, then
   // pop the scoreboard at handoff and compare.
   task automatic do_op(input string name, input logic w, input logic s,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eq, input logic [63:0] er,
                        input int lat, input int hold);
      int          n;
      bit          seen;
      logic [63:0] hq, hr;
      exp_t        e;
      @(negedge clk);
      chk({name, "_ready"}, 64'(div_ready), 64'd1);
      divw = w; div_signed = s; dividend = a; divisor = b; div_valid = 1'b1;
      @(posedge clk);
      sb_q.push_back('{q: eq, r: er});
      #1;
      div_valid = 1'b0;
      // Operands must be ignored after accept.
      dividend = {$urandom, $urandom};
      divisor  = {$urandom, $urandom};
      n = 0; seen = 0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         if (out_valid) seen = 1;
      end
      chk({name, "_latency"}, 64'(n), 64'(lat));
      if (!seen) begin
         void'(sb_q.pop_front());
         return;
      end
      hq = quotient; hr = remainder;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({name, "_hold_valid"}, 64'(out_valid), 64'd1);
         chk({name, "_hold_ready"}, 64'(div_ready), 64'd0);
         chk({name, "_hold_q"}, quotient, hq);
         chk({name, "_hold_r"}, remainder, hr);
      end
      out_ready = 1'b1;
      if (sb_q.size() == 0) begin
         chk({name, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         chk({name, "_q"}, quotient, e.q);
         chk({name, "_r"}, remainder, e.r);
      end
      $display("op %s a=0x%016h b=0x%016h q=0x%016h r=0x%016h lat=%0d", name, a, b, quotient, remainder, n);
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk({name, "_ready_after"}, 64'(div_ready), 64'd1);
      chk({name, "_valid_after"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{"divu_100_7",   0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 66};
      vecs[1]  = '{"div_m7_2",     0, 1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66};
      vecs[2]  = '{"div_7_m2",     0, 1, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66};
      vecs[3]  = '{"div_m7_m2",    0, 1, -64'sd7, -64'sd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 66};
      vecs[4]  = '{"divu_5_0",     0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1};
      vecs[5]  = '{"divuw_wzero",  1, 0, 64'h1_0000_0005, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1};
      vecs[6]  = '{"div_ovf",      0, 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 1};
      vecs[7]  = '{"divw_ovf",     1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0, 1};
      vecs[8]  = '{"divuw_ff_1",   1, 0, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 34};
      vecs[9]  = '{"divu_max_16",  0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 64'd15, 66};
      vecs[10] = '{"divw_m100_7",  1, 1, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 34};
      vecs[11] = '{"divuw_hi_7",   1, 0, 64'h1234_5678_0000_0064, 64'h5555_0000_0000_0007, 64'd14, 64'd2, 34};
      vecs[12] = '{"divu_0_5",     0, 0, 64'd0, 64'd5, 64'd0, 64'd0, 66};
      vecs[13] = '{"div_min_2",    0, 1, 64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 64'd0, 66};
      vecs[14] = '{"divw_zero_neg",1, 1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1};

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 64'(div_ready), 64'd1);
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_q", quotient, 64'd0);
      chk("reset_r", remainder, 64'd0);
      rst = 1'b0;

      foreach (vecs[i])
         do_op(vecs[i].name, vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].b,
               vecs[i].q, vecs[i].r, vecs[i].lat, 0);

      // Flush in cycle T+10 of a 64-bit divide.
      begin
         int  n;
         bit  stray;
         @(negedge clk);
         divw = 1'b0; div_signed = 1'b0; dividend = 64'd1000; divisor = 64'd3; div_valid = 1'b1;
         @(posedge clk);
         #1 div_valid = 1'b0;
         repeat (9) @(posedge clk);
         #1 flush = 1'b1;
         @(posedge clk);
         #1 flush = 1'b0;
         @(negedge clk);
         chk("flush_ready_next", 64'(div_ready), 64'd1);
         stray = 0;
         for (n = 0; n < 80; n++) begin
            @(negedge clk);
            if (out_valid) stray = 1;
         end
         chk("flush_no_valid", 64'(stray), 64'd0);
         $display("op flush_mid_calc ready=%0d stray_valid=%0d", div_ready, stray);
      end
      do_op("div_9_3_after_flush", 0, 1, 64'd9, 64'd3, 64'd3, 64'd0, 66, 0);

      // Request coinciding with flush must be dropped.
      @(negedge clk);
      dividend = 64'd5; divisor = 64'd0; div_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 div_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_req_dropped_ready", 64'(div_ready), 64'd1);
      chk("flush_req_dropped_valid", 64'(out_valid), 64'd0);
      $display("op req_with_flush ready=%0d valid=%0d", div_ready, out_valid);

      // Stall in DONE for 5 cycles.
      do_op("divu_50_5_hold", 0, 0, 64'd50, 64'd5, 64'd10, 64'd0, 66, 5);

      // Immediate back-to-back request right after handoff.
      do_op("divuw_b2b", 1, 0, 64'd77, 64'd10, 64'd7, 64'd7, 34, 0);

      // Asynchronous reset mid-operation clears everything at once.
      @(negedge clk);
      divw = 1'b0; div_signed = 1'b0; dividend = 64'd12345; divisor = 64'd10; div_valid = 1'b1;
      @(posedge clk);
      #1 div_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_ready", 64'(div_ready), 64'd1);
      chk("async_rst_valid", 64'(out_valid), 64'd0);
      chk("async_rst_q", quotient, 64'd0);
      chk("async_rst_r", remainder, 64'd0);
      $display("op async_reset q=0x%016h r=0x%016h", quotient, remainder);
      @(negedge clk);
      rst = 1'b0;
      do_op("divu_after_rst", 0, 0, 64'd12345, 64'd10, 64'd1234, 64'd5, 66, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_22040632_divider.md
# ysyx_22040632_divider

Iterative radix-2 restoring divider for the RV64M extension unit; the inverse-direction companion of the Wallace-tree multiplier path in `alu_ext`. It accepts one DIV/DIVU/REM/REMU (64-bit) or DIVW/DIVUW/REMW/REMUW (32-bit) operation through a valid/ready handshake. It returns both quotient and remainder, held until the EXU consumes them. It is multicycle (one bit per cycle) and can be flushed by the pipeline at any time.

## Interface
Parameters:
- `XLEN`, 64, operand/result width (only 64 supported).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `div_valid`  in  1  request valid.
- `div_ready`  out  1  divider idle; request accepted when `div_valid && div_ready && !flush`.
- `divw`  in  1  word operation (32-bit).
- `div_signed`  in  1  signed operation.
- `dividend`  in  XLEN  dividend (rs1).
- `divisor`  in  XLEN  divisor (rs2).
- `flush`  in  1  abort current operation.
- `out_valid`  out  1  quotient/remainder valid.
- `out_ready`  in  1  consumer takes result.
- `quotient`  out  XLEN  quotient.
- `remainder`  out  XLEN  remainder.

## Operation
- States: IDLE, CALC, FIX, DONE. `div_ready` = (state==IDLE). `out_valid` = (state==DONE).
- IDLE→CALC on accept, for the normal case.
- IDLE→DONE on accept for a special case:
  - Divisor==0: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend; remainder = 0.
- Special cases are checked on the width-adjusted operands.
- Word mode operand adjustment: operands are the low 32 bits, sign-extended if `div_signed`, else zero-extended.
- Latched on accept: operand magnitudes (absolute value if signed); quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend); N = 32 (word) or 64; iteration counter = 0.
- CALC, once per cycle:
  - Shift {partial_rem[XLEN:0], dividend_shift} left by 1.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and set quotient LSB = 1; else restore and set LSB = 0.
  - After iteration N−1, go to FIX.
- FIX: negate the quotient if its sign flag is set; negate the remainder if its sign flag is set (signed only). Go to DONE.
- Word-mode results: the 32-bit quotient/remainder are sign-extended from bit 31 to XLEN, for both signed and unsigned word ops (RV64 rule).
- DONE: hold `quotient`/`remainder` stable. On `out_ready`, go to IDLE.
- Flush: takes priority in every state. The next state is IDLE and `out_valid` drops next cycle. A request with `flush` high in the same cycle is not accepted.
- Reset values: state IDLE, `div_ready`=1, `out_valid`=0, `quotient`=0, `remainder`=0, counter 0.

## Timing
- Accept at cycle T. Normal 64-bit: CALC T+1..T+64, FIX T+65, `out_valid` first high at T+66. Normal word: `out_valid` at T+34.
- Special cases: `out_valid` at T+1.
- Result handoff at cycle D (`out_valid && out_ready`): `div_ready` high at D+1. The earliest next accept is D+1. There is no overlap of result and new request.
- `out_ready` low: outputs held bit-stable indefinitely.
- Asserting `rst` mid-operation clears everything immediately (asynchronous). No partial result is visible afterwards.
- Flush in cycle F: `div_ready`=1 at F+1. A new request accepted at F+1 produces a correct result, uncorrupted by leftover state.
- Inputs are sampled only at accept. Changes to `dividend`/`divisor` afterwards have no effect.

## Structure
- Package `ysyx_22040632_div_pkg`:
  - state enum (IDLE, CALC, FIX, DONE);
  - `XLEN`, word and doubleword iteration counts (32, 64);
  - `DIV_ZERO_Q` constant (all ones).
- Sub-module `ysyx_22040632_div_step`: purely combinational single restoring iteration (partial remainder in, divisor in → next partial remainder, quotient bit). Instantiated once; the FSM and registers live in the top.

## Test plan
- Unsigned 64-bit 100 / 7, accept at T → `out_valid` at T+66, q=14, r=2.
- Signed −7 / 2 → q=−3 (0xFFFF_FFFF_FFFF_FFFD), r=−1. Then 7 / −2 → q=−3, r=1.
- Divide by zero 5 / 0 → at T+1, q=0xFFFF_FFFF_FFFF_FFFF, r=5. DIVUW 0x1_0000_0005 / 0x1_0000_0000 → q=all ones, r=5 (word divisor zero).
- Overflow 0x8000_0000_0000_0000 / −1 signed → at T+1, q=0x8000_0000_0000_0000, r=0. DIVW 0x8000_0000 / 0xFFFF_FFFF → q=0xFFFF_FFFF_8000_0000, r=0.
- DIVUW 0xFFFF_FFFF / 1 → `out_valid` at T+34, q=0xFFFF_FFFF_FFFF_FFFF (sign-extended), r=0.
- Flush at T+10 of a 64-bit divide → `out_valid` never asserts, `div_ready`=1 at T+11. Then 9 / 3 → q=3, r=0. Also hold `out_ready`=0 for 5 cycles in DONE → outputs unchanged, `div_ready` stays 0.
